// File: rtl/axis_demux.sv
// axis_demux: 1-to-2 AXI-stream packet demultiplexer.
//
// The destination is taken from `sel` on the first beat of a packet and held
// until that packet's tlast beat is accepted. Each output has a one-entry
// register stage that supports a simultaneous drain and load, so a stream runs
// at one beat per cycle.
//
// Optional feature: define AXIS_DEMUX_PKT_CNT_EN to add the per-output packet
// counters pkt_count_0/pkt_count_1 (completed tlast handshakes, wrapping).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   sel                           destination select (first beat only)
//   input_t{data,valid,ready,last} input stream
//   output_t{data,valid,ready,last}_0/_1  output streams 0 and 1
//   pkt_count_0/_1                packet counters (AXIS_DEMUX_PKT_CNT_EN only)

module axis_demux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] input_tdata,
  input  logic                  input_tvalid,
  output logic                  input_tready,
  input  logic                  input_tlast,
  output logic [DATA_WIDTH-1:0] output_tdata_0,
  output logic                  output_tvalid_0,
  input  logic                  output_tready_0,
  output logic                  output_tlast_0,
  output logic [DATA_WIDTH-1:0] output_tdata_1,
  output logic                  output_tvalid_1,
  input  logic                  output_tready_1,
  output logic                  output_tlast_1
`ifdef AXIS_DEMUX_PKT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pkt_count_0,
  output logic [CNT_WIDTH-1:0]  pkt_count_1
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy0 = 2'd1;
  localparam logic [1:0] StBusy1 = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  route;
  logic                  accept;
  logic                  load_0, load_1;

  logic                  vld_0_q, vld_0_d, vld_1_q, vld_1_d;
  logic                  last_0_q, last_0_d, last_1_q, last_1_d;
  logic [DATA_WIDTH-1:0] data_0_q, data_0_d, data_1_q, data_1_d;

  // In IDLE the route follows sel directly; inside a packet it is locked.
  always_comb begin
    unique case (state_q)
      StBusy0: route = 1'b0;
      StBusy1: route = 1'b1;
      default: route = sel;
    endcase
  end

  // Only the routed output's register matters for acceptance.
  always_comb begin
    if (route) input_tready = !vld_1_q || output_tready_1;
    else       input_tready = !vld_0_q || output_tready_0;
  end

  assign accept = input_tvalid && input_tready;
  assign load_0 = accept && !route;
  assign load_1 = accept && route;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (input_tlast)          state_d = StIdle;
      else if (state_q == StIdle) state_d = route ? StBusy1 : StBusy0;
    end
  end

  // Output registers: a load wins over a drain, so drain+load replaces in place.
  always_comb begin
    vld_0_d  = vld_0_q;
    last_0_d = last_0_q;
    data_0_d = data_0_q;
    if (load_0) begin
      vld_0_d  = 1'b1;
      last_0_d = input_tlast;
      data_0_d = input_tdata;
    end else if (output_tready_0) begin
      vld_0_d  = 1'b0;
    end
  end

  always_comb begin
    vld_1_d  = vld_1_q;
    last_1_d = last_1_q;
    data_1_d = data_1_q;
    if (load_1) begin
      vld_1_d  = 1'b1;
      last_1_d = input_tlast;
      data_1_d = input_tdata;
    end else if (output_tready_1) begin
      vld_1_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      vld_0_q  <= 1'b0;
      last_0_q <= 1'b0;
      data_0_q <= '0;
      vld_1_q  <= 1'b0;
      last_1_q <= 1'b0;
      data_1_q <= '0;
    end else begin
      state_q  <= state_d;
      vld_0_q  <= vld_0_d;
      last_0_q <= last_0_d;
      data_0_q <= data_0_d;
      vld_1_q  <= vld_1_d;
      last_1_q <= last_1_d;
      data_1_q <= data_1_d;
    end
  end

  assign output_tdata_0  = data_0_q;
  assign output_tvalid_0 = vld_0_q;
  assign output_tlast_0  = last_0_q;
  assign output_tdata_1  = data_1_q;
  assign output_tvalid_1 = vld_1_q;
  assign output_tlast_1  = last_1_q;

`ifdef AXIS_DEMUX_PKT_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_0_q, cnt_0_d, cnt_1_q, cnt_1_d;

  always_comb begin
    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if (vld_0_q && output_tready_0 && last_0_q) cnt_0_d = cnt_0_q + CntOne;
    if (vld_1_q && output_tready_1 && last_1_q) cnt_1_d = cnt_1_q + CntOne;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign pkt_count_0 = cnt_0_q;
  assign pkt_count_1 = cnt_1_q;
`else
  // Packet counters not built.
`endif

endmodule

// File: tb/tb_axis_demux.sv
module tb_axis_demux;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel;
  logic [DW-1:0] input_tdata;
  logic          input_tvalid;
  logic          input_tready;
  logic          input_tlast;
  logic [DW-1:0] output_tdata_0, output_tdata_1;
  logic          output_tvalid_0, output_tvalid_1;
  logic          output_tready_0, output_tready_1;
  logic          output_tlast_0, output_tlast_1;
`ifdef AXIS_DEMUX_PKT_CNT_EN
  logic [CW-1:0] pkt_count_0, pkt_count_1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .sel             (sel),
    .input_tdata     (input_tdata),
    .input_tvalid    (input_tvalid),
    .input_tready    (input_tready),
    .input_tlast     (input_tlast),
    .output_tdata_0  (output_tdata_0),
    .output_tvalid_0 (output_tvalid_0),
    .output_tready_0 (output_tready_0),
    .output_tlast_0  (output_tlast_0),
    .output_tdata_1  (output_tdata_1),
    .output_tvalid_1 (output_tvalid_1),
    .output_tready_1 (output_tready_1),
    .output_tlast_1  (output_tlast_1)
`ifdef AXIS_DEMUX_PKT_CNT_EN
    ,
    .pkt_count_0     (pkt_count_0),
    .pkt_count_1     (pkt_count_1)
`endif
  );

  task automatic do_reset();
    reset = 1'b1; sel = 1'b0; input_tdata = '0; input_tvalid = 1'b0; input_tlast = 1'b0;
    output_tready_0 = 1'b0; output_tready_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    input_tvalid = 1'b0; output_tready_0 = 1'b1; output_tready_1 = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++; if (output_tvalid_0 !== 1'b0) begin n_err++; $display("FAIL rst_vld0 got %b want 0", output_tvalid_0); end
    n_vec++; if (output_tvalid_1 !== 1'b0) begin n_err++; $display("FAIL rst_vld1 got %b want 0", output_tvalid_1); end
    n_vec++; if (output_tdata_0 !== 8'h00) begin n_err++; $display("FAIL rst_data0 got %h want 00", output_tdata_0); end
    n_vec++; if (output_tdata_1 !== 8'h00) begin n_err++; $display("FAIL rst_data1 got %h want 00", output_tdata_1); end
    n_vec++; if (input_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready got %b want 1", input_tready); end
`ifdef AXIS_DEMUX_PKT_CNT_EN
    n_vec++; if (pkt_count_0 !== '0 || pkt_count_1 !== '0) begin
      n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", pkt_count_0, pkt_count_1); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    output_tready_0 = 1'b1; output_tready_1 = 1'b1;
    sel = 1'b0; input_tdata = 8'hAA; input_tlast = 1'b1; input_tvalid = 1'b1;
    @(negedge clk);
    n_vec++; if (input_tready !== 1'b1) begin n_err++; $display("FAIL single_tready got %b want 1", input_tready); end
    @(posedge clk); #1 input_tvalid = 1'b0;
    @(negedge clk);
    n_vec++; if ({output_tvalid_0, output_tlast_0, output_tdata_0} !== {1'b1, 1'b1, 8'hAA}) begin
      n_err++; $display("FAIL single_out0 got v%b l%b %h want v1 l1 aa", output_tvalid_0, output_tlast_0, output_tdata_0); end
    n_vec++; if (output_tvalid_1 !== 1'b0) begin n_err++; $display("FAIL single_vld1 got %b want 0", output_tvalid_1); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (output_tvalid_0 !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", output_tvalid_0); end
    idle(1);
  endtask

  task automatic test_sel_lock();
    logic [7:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    output_tready_0 = 1'b1; output_tready_1 = 1'b1;
    sel = 1'b1; input_tdata = beats[0]; input_tlast = 1'b0; input_tvalid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        sel = 1'b0; input_tdata = beats[i+1]; input_tlast = (i == 1);
      end else begin
        input_tvalid = 1'b0;
      end
      @(negedge clk);
      n_vec++; if ({output_tvalid_1, output_tlast_1, output_tdata_1} !== {1'b1, i == 2, beats[i]}) begin
        n_err++; $display("FAIL lock_beat%0d got v%b l%b %h want v1 l%b %h", i, output_tvalid_1,
                          output_tlast_1, output_tdata_1, i == 2, beats[i]); end
      n_vec++; if (output_tvalid_0 !== 1'b0) begin n_err++; $display("FAIL lock_out0_%0d got %b want 0", i, output_tvalid_0); end
      @(posedge clk); #1;
    end
    idle(1);
  endtask

  task automatic test_stall();
    output_tready_0 = 1'b0; output_tready_1 = 1'b1;
    sel = 1'b0; input_tdata = 8'hAA; input_tlast = 1'b0; input_tvalid = 1'b1;
    @(negedge clk);
    n_vec++; if (input_tready !== 1'b1) begin n_err++; $display("FAIL stall_empty_tready got %b want 1", input_tready); end
    @(posedge clk); #1;
    sel = 1'b1; input_tdata = 8'hBB; input_tlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (input_tready !== 1'b0) begin n_err++; $display("FAIL stall_tready%0d got %b want 0", i, input_tready); end
      n_vec++; if ({output_tvalid_0, output_tlast_0, output_tdata_0} !== {1'b1, 1'b0, 8'hAA}) begin
        n_err++; $display("FAIL stall_hold%0d got v%b l%b %h want v1 l0 aa", i, output_tvalid_0, output_tlast_0, output_tdata_0); end
      @(posedge clk); #1;
    end
    output_tready_0 = 1'b1;
    @(negedge clk);
    n_vec++; if (input_tready !== 1'b1) begin n_err++; $display("FAIL stall_release got %b want 1", input_tready); end
    @(posedge clk); #1 input_tvalid = 1'b0;
    @(negedge clk);
    n_vec++; if ({output_tvalid_0, output_tlast_0, output_tdata_0} !== {1'b1, 1'b1, 8'hBB}) begin
      n_err++; $display("FAIL stall_second got v%b l%b %h want v1 l1 bb", output_tvalid_0, output_tlast_0, output_tdata_0); end
    n_vec++; if (output_tvalid_1 !== 1'b0) begin n_err++; $display("FAIL stall_out1 got %b want 0", output_tvalid_1); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (output_tvalid_0 !== 1'b0) begin n_err++; $display("FAIL stall_once got %b want 0", output_tvalid_0); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    output_tready_0 = 1'b1; output_tready_1 = 1'b1;
    sel = 1'b1; input_tdata = 8'hC1; input_tlast = 1'b0; input_tvalid = 1'b1;
    @(posedge clk); #1 input_tdata = 8'hC2;
    @(posedge clk); #1;
    reset = 1'b1; input_tvalid = 1'b0; output_tready_1 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_vec++; if (output_tvalid_1 !== 1'b0) begin n_err++; $display("FAIL midrst_vld1 got %b want 0", output_tvalid_1); end
    sel = 1'b0; input_tdata = 8'h5A; input_tlast = 1'b1; input_tvalid = 1'b1;
    @(posedge clk); #1 input_tvalid = 1'b0;
    @(negedge clk);
    n_vec++; if ({output_tvalid_0, output_tdata_0} !== {1'b1, 8'h5A}) begin
      n_err++; $display("FAIL midrst_out0 got v%b %h want v1 5a", output_tvalid_0, output_tdata_0); end
    n_vec++; if (output_tvalid_1 !== 1'b0) begin n_err++; $display("FAIL midrst_resid got %b want 0", output_tvalid_1); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic       ps [5];
    logic [7:0] pd [5];
    do_reset();
    output_tready_0 = 1'b1; output_tready_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin ps[i] = (i % 2 == 1); pd[i] = 8'($urandom); end
    sel = ps[0]; input_tdata = pd[0]; input_tlast = 1'b1; input_tvalid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin sel = ps[i+1]; input_tdata = pd[i+1]; end
      else input_tvalid = 1'b0;
      @(negedge clk);
      if (ps[i]) begin
        n_vec++; if ({output_tvalid_1, output_tdata_1, output_tvalid_0} !== {1'b1, pd[i], 1'b0}) begin
          n_err++; $display("FAIL b2b_%0d got v1=%b %h v0=%b want v1=1 %h v0=0", i, output_tvalid_1,
                            output_tdata_1, output_tvalid_0, pd[i]); end
      end else begin
        n_vec++; if ({output_tvalid_0, output_tdata_0, output_tvalid_1} !== {1'b1, pd[i], 1'b0}) begin
          n_err++; $display("FAIL b2b_%0d got v0=%b %h v1=%b want v0=1 %h v1=0", i, output_tvalid_0,
                            output_tdata_0, output_tvalid_1, pd[i]); end
      end
      if (i < 4) begin
        n_vec++; if (input_tready !== 1'b1) begin n_err++; $display("FAIL b2b_tready%0d got %b want 1", i, input_tready); end
      end
      @(posedge clk); #1;
    end
`ifdef AXIS_DEMUX_PKT_CNT_EN
    @(negedge clk);
    n_vec++; if (pkt_count_0 !== 16'd3 || pkt_count_1 !== 16'd2) begin
      n_err++; $display("FAIL b2b_cnt got %0d/%0d want 3/2", pkt_count_0, pkt_count_1); end
`endif
    idle(1);
  endtask

  // Random traffic against a packet-level model: per-output queues of pending
  // beats (at most one each), and the destination of any open packet.
  task automatic test_random();
    logic [DW:0] q0 [$];
    logic [DW:0] q1 [$];
    logic        in_pkt, dest, route, rdy_exp, acc, stall0, stall1;
    logic [DW:0] held0, held1, exp;
    int          cnt0, cnt1;
    do_reset();
    in_pkt = 1'b0; dest = 1'b0; acc = 1'b1; stall0 = 1'b0; stall1 = 1'b0;
    held0 = '0; held1 = '0; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!input_tvalid || acc) begin
        input_tvalid = ($urandom_range(0, 9) < 7);
        sel          = 1'($urandom);
        input_tlast  = ($urandom_range(0, 9) < 3);
        input_tdata  = 8'($urandom);
      end
      output_tready_0 = ($urandom_range(0, 3) != 0);
      output_tready_1 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      route   = in_pkt ? dest : sel;
      rdy_exp = route ? (q1.size() == 0 || output_tready_1) : (q0.size() == 0 || output_tready_0);
      n_vec++; if (input_tready !== rdy_exp) begin n_err++; $display("FAIL rnd_tready c%0d got %b want %b", c, input_tready, rdy_exp); end
      n_vec++; if (output_tvalid_0 !== (q0.size() != 0)) begin
        n_err++; $display("FAIL rnd_vld0 c%0d got %b want %b", c, output_tvalid_0, q0.size() != 0); end
      n_vec++; if (output_tvalid_1 !== (q1.size() != 0)) begin
        n_err++; $display("FAIL rnd_vld1 c%0d got %b want %b", c, output_tvalid_1, q1.size() != 0); end
      if (stall0 && output_tvalid_0) begin
        n_vec++; if ({output_tlast_0, output_tdata_0} !== held0) begin
          n_err++; $display("FAIL rnd_stable0 c%0d got %h want %h", c, {output_tlast_0, output_tdata_0}, held0); end
      end
      if (stall1 && output_tvalid_1) begin
        n_vec++; if ({output_tlast_1, output_tdata_1} !== held1) begin
          n_err++; $display("FAIL rnd_stable1 c%0d got %h want %h", c, {output_tlast_1, output_tdata_1}, held1); end
      end
      if (q0.size() != 0 && output_tready_0) begin
        exp = q0.pop_front();
        if (exp[DW]) cnt0++;
        n_vec++; if ({output_tlast_0, output_tdata_0} !== exp) begin
          n_err++; $display("FAIL rnd_out0 c%0d got %h want %h", c, {output_tlast_0, output_tdata_0}, exp); end
      end
      if (q1.size() != 0 && output_tready_1) begin
        exp = q1.pop_front();
        if (exp[DW]) cnt1++;
        n_vec++; if ({output_tlast_1, output_tdata_1} !== exp) begin
          n_err++; $display("FAIL rnd_out1 c%0d got %h want %h", c, {output_tlast_1, output_tdata_1}, exp); end
      end
      stall0 = output_tvalid_0 && !output_tready_0; held0 = {output_tlast_0, output_tdata_0};
      stall1 = output_tvalid_1 && !output_tready_1; held1 = {output_tlast_1, output_tdata_1};
      acc = input_tvalid && rdy_exp;
      if (acc) begin
        if (route) q1.push_back({input_tlast, input_tdata});
        else       q0.push_back({input_tlast, input_tdata});
        in_pkt = !input_tlast;
        dest   = route;
      end
      @(posedge clk); #1;
    end
    idle(3);
`ifdef AXIS_DEMUX_PKT_CNT_EN
    for (int i = 0; i < q0.size(); i++) if (q0[i][DW]) cnt0++;
    for (int i = 0; i < q1.size(); i++) if (q1[i][DW]) cnt1++;
    @(negedge clk);
    n_vec++; if (pkt_count_0 !== CW'(cnt0) || pkt_count_1 !== CW'(cnt1)) begin
      n_err++; $display("FAIL rnd_cnt got %0d/%0d want %0d/%0d", pkt_count_0, pkt_count_1, cnt0, cnt1); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_sel_lock();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
